div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
Sequencing controller between the EX stage and the pipelined signed/unsigned divider cores, and owner of the architectural HI/LO registers.
- Accepts DIV/DIVU requests and issues a single-cycle operand-valid to the core.
- Stalls the pipeline while the divide is in flight and commits {quotient, remainder} to LO/HI.
- Handles MTHI/MTLO writes and flushes that arrive mid-operation; an in-flight core operation cannot be cancelled, so it is drained.

Parameters:
DATA_W, 32, operand/result width
TIMEOUT, 40, max cycles in WAIT/DRAIN before watchdog abort
CNT_W, 6, watchdog counter width (must hold TIMEOUT)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  EX holds a DIV/DIVU
req_signed  in  1  1=DIV, 0=DIVU
req_src1  in  DATA_W  dividend
req_src2  in  DATA_W  divisor
flush  in  1  exception/ERET flush of EX and younger stages
core_valid  out  1  one-cycle operand valid to divider
core_signed  out  1  selects signed core
core_dividend  out  DATA_W  latched dividend
core_divisor  out  DATA_W  latched divisor
core_dout_valid  in  1  result valid from selected core
core_dout_data  in  2*DATA_W  {quotient[63:32], remainder[31:0]}
mthi_we  in  1  MTHI commit
mtlo_we  in  1  MTLO commit
mt_wdata  in  DATA_W  MTHI/MTLO data
stall_o  out  1  hold IF..EX
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse
hi_o  out  DATA_W  HI register
lo_o  out  DATA_W  LO register
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (sync, active-high): state=IDLE; hi_o=lo_o=0; core_* =0; done_o=0; timeout_err=0; counter=0.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE:
  - req_valid & !flush → latch src1/src2/signed, go ISSUE.
  - stall_o = req_valid & !flush, combinational, same cycle.
- ISSUE:
  - core_valid=1 for exactly this cycle, operands from latches.
  - If flush: core_valid forced 0, go IDLE.
  - Otherwise go WAIT, counter=0.
  - stall_o=1.
- WAIT:
  - stall_o=1; counter increments each cycle.
  - core_dout_valid → LO←data[63:32], HI←data[31:0] at this edge, go DONE.
  - flush (without dout_valid) → go DRAIN.
  - counter==TIMEOUT-1 → set timeout_err, go IDLE, HI/LO unchanged.
- DONE:
  - done_o=1, stall_o=0; EX advances this cycle.
  - req_valid is ignored here (same instruction); next state is IDLE.
  - Flush in DONE does not roll back HI/LO.
- DRAIN:
  - stall_o = req_valid (holds a new request until IDLE); busy_o=1; counter runs.
  - core_dout_valid → result discarded, go IDLE.
  - Timeout → timeout_err, go IDLE.
- Latency: request in cycle 0, core_valid in cycle 1, core result in cycle 1+L, HI/LO visible cycle 2+L, done_o in cycle 2+L. Back-to-back divides: next ISSUE no earlier than cycle 4+L.
- core_dividend/core_divisor/core_signed hold the latched values from ISSUE until next latch. core_dout_valid outside WAIT/DRAIN is ignored.
- MTHI/MTLO:
  - Write in any state.
  - If the same cycle as result commit, the divider result wins (older MT in later stage is superseded by the younger divide).
  - mthi_we and mtlo_we may both be set; each writes mt_wdata.
- Watchdog counter saturates and is cleared on entry to WAIT/DRAIN.
- timeout_err is cleared only by rst.

Optional Feature:
DIV_ZERO_BYPASS_EN:
- Defined: in IDLE, req_src2==0 skips ISSUE/WAIT and goes straight to DONE next cycle. LO←32'hFFFF_FFFF, HI←req_src1 at the accept edge; core_valid never asserted; stall_o=1 only in the accept cycle.
- Undefined: a zero divisor is issued to the core like any other operand, and HI/LO take whatever the core returns.

Test Plan:
- DIVU 100/7, core L=10 → core_valid 1 cycle at cycle 1; at done_o: lo_o=14, hi_o=2; stall_o high cycles 0..11, low in DONE.
- DIV 0xFFFFFFF9/2 signed → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; core_signed=1.
- DIVU 50/5 issued, flush asserted 3 cycles into WAIT; core returns 10/0 later → HI/LO keep prior values (0x1234/0x5678), no done_o, busy_o low after dout.
- New request during DRAIN → stall_o high until IDLE, then normal completion with correct HI/LO.
- mthi_we with 0xAAAA in the same cycle as result commit of 9/4 → hi_o=1 (divider wins), lo_o=2; mtlo_we 0x55 one cycle later → lo_o=0x55.
- Core never returns dout_valid → timeout_err=1 after TIMEOUT cycles, state IDLE, HI/LO unchanged. With DIV_ZERO_BYPASS_EN, DIVU 7/0 → done_o at cycle 1, lo_o=0xFFFFFFFF, hi_o=7, core_valid never high.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl -- sequencing controller between the EX stage and the divider cores.
//
// Accepts DIV/DIVU requests from EX, hands latched operands to the divider with
// a one-cycle core_valid, stalls IF..EX while the divide is in flight and commits
// {quotient, remainder} into LO/HI. A flush while the core is busy cannot cancel
// the core operation, so the controller drains it and discards the result.
// MTHI/MTLO may write HI/LO in any state; a divide result committing in the same
// cycle takes priority. A watchdog aborts WAIT/DRAIN after TIMEOUT cycles and
// raises a sticky timeout_err.
//
// Optional feature macro: DIV_ZERO_BYPASS_EN
//   defined   : a zero divisor completes without the core (LO=all ones, HI=dividend)
//   undefined : a zero divisor is issued to the core like any other operand
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_signed        DIV/DIVU request from EX (1 = signed)
//   req_src1/req_src2           dividend / divisor
//   flush                       flush of EX and younger stages
//   core_valid/core_signed      operand valid pulse and core select
//   core_dividend/core_divisor  latched operands
//   core_dout_valid/data        core result {quotient, remainder}
//   mthi_we/mtlo_we/mt_wdata    MTHI/MTLO commit
//   stall_o/busy_o/done_o       pipeline stall, not-idle, completion pulse
//   hi_o/lo_o                   architectural HI/LO
//   timeout_err                 sticky watchdog flag
module div_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_signed,
    input  logic [DATA_W-1:0]     req_src1,
    input  logic [DATA_W-1:0]     req_src2,
    input  logic                  flush,
    output logic                  core_valid,
    output logic                  core_signed,
    output logic [DATA_W-1:0]     core_dividend,
    output logic [DATA_W-1:0]     core_divisor,
    input  logic                  core_dout_valid,
    input  logic [2*DATA_W-1:0]   core_dout_data,
    input  logic                  mthi_we,
    input  logic                  mtlo_we,
    input  logic [DATA_W-1:0]     mt_wdata,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_done;
    logic                r_timeout;
    logic                r_core_signed;
    logic [DATA_W-1:0]   r_dividend;
    logic [DATA_W-1:0]   r_divisor;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_accept;
    logic                w_tmo_hit;
    logic                w_stall;

    // Watchdog counter holds at its maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign w_accept  = (r_state == S_IDLE) && req_valid && !flush;
    assign w_tmo_hit = (r_cnt == TMO_LAST);

    // A flush in ISSUE must suppress the operand pulse in that same cycle.
    assign core_valid = (r_state == S_ISSUE) && !flush;

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:          w_stall = req_valid && !flush;
            S_ISSUE, S_WAIT: w_stall = 1'b1;
            S_DRAIN:         w_stall = req_valid;
            default:         w_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_core_signed <= 1'b0;
            r_dividend    <= '0;
            r_divisor     <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
        end else begin
            r_done <= 1'b0;

            // MT writes go first so a same-edge divide commit below overrides them.
            if (mthi_we) r_hi <= mt_wdata;
            if (mtlo_we) r_lo <= mt_wdata;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
`ifdef DIV_ZERO_BYPASS_EN
                        if (req_src2 == '0) begin
                            r_lo    <= '1;
                            r_hi    <= req_src1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_core_signed <= req_signed;
                            r_dividend    <= req_src1;
                            r_divisor     <= req_src2;
                            r_state       <= S_ISSUE;
                        end
`else
                        r_core_signed <= req_signed;
                        r_dividend    <= req_src1;
                        r_divisor     <= req_src2;
                        r_state       <= S_ISSUE;
`endif
                    end
                end

                S_ISSUE: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    r_cnt <= sat_inc(r_cnt);
                    if (core_dout_valid) begin
                        r_lo    <= core_dout_data[2*DATA_W-1:DATA_W];
                        r_hi    <= core_dout_data[DATA_W-1:0];
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (flush) begin
                        // Core op cannot be cancelled; wait it out and drop the result.
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end else if (w_tmo_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                S_DRAIN: begin
                    r_cnt <= sat_inc(r_cnt);
                    if (core_dout_valid) begin
                        r_state <= S_IDLE;
                    end else if (w_tmo_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core_signed   = r_core_signed;
    assign core_dividend = r_dividend;
    assign core_divisor  = r_divisor;
    assign stall_o       = w_stall;
    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = r_done;
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;
    assign timeout_err   = r_timeout;

endmodule

// File: tb/tb_div_ctrl.sv
// Testbench for div_ctrl: table of divide vectors, hand-written flush/drain,
// MT-race, ISSUE-flush and watchdog sequences, then randomized divides checked
// against arithmetic expectations. A behavioural divider core answers each
// core_valid pulse after a programmable latency.
module tb_div_ctrl;

    localparam int TMO = 40;
`ifdef DIV_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid, req_signed;
    logic [31:0] req_src1, req_src2;
    logic        flush;
    logic        core_valid, core_signed;
    logic [31:0] core_dividend, core_divisor;
    logic        core_dout_valid;
    logic [63:0] core_dout_data;
    logic        mthi_we, mtlo_we;
    logic [31:0] mt_wdata;
    logic        stall_o, busy_o, done_o, timeout_err;
    logic [31:0] hi_o, lo_o;

    div_ctrl #(.DATA_W(32), .TIMEOUT(TMO), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_signed(req_signed),
        .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .core_valid(core_valid), .core_signed(core_signed),
        .core_dividend(core_dividend), .core_divisor(core_divisor),
        .core_dout_valid(core_dout_valid), .core_dout_data(core_dout_data),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_wdata(mt_wdata),
        .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
        .hi_o(hi_o), .lo_o(lo_o), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Quotient/remainder as the divider returns them; zero divisor gives all-ones/dividend.
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {q[31:0], r[31:0]};
        end
        return {a / b, a % b};
    endfunction

    // Behavioural divider core
    int          core_lat  = 1;
    bit          core_mute = 1'b0;
    bit          pend;
    int          pcnt;
    logic [63:0] pres;

    always @(posedge clk) begin
        if (rst) begin
            core_dout_valid <= 1'b0;
            core_dout_data  <= '0;
            pend            <= 1'b0;
            pcnt            <= 0;
        end else begin
            core_dout_valid <= 1'b0;
            if (pend) begin
                if (pcnt <= 1) begin
                    core_dout_valid <= 1'b1;
                    core_dout_data  <= pres;
                    pend            <= 1'b0;
                end else begin
                    pcnt <= pcnt - 1;
                end
            end
            if (core_valid && !core_mute) begin
                if (core_lat <= 1) begin
                    core_dout_valid <= 1'b1;
                    core_dout_data  <= ref_div(core_signed, core_dividend, core_divisor);
                end else begin
                    pend <= 1'b1;
                    pcnt <= core_lat - 1;
                    pres <= ref_div(core_signed, core_dividend, core_divisor);
                end
            end
        end
    end

    int cv_cnt   = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        if (core_valid) cv_cnt   <= cv_cnt + 1;
        if (done_o)     done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current cycle (cycle 0) and hold it until done_o.
    task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input int lat, output int dcyc, output int scnt);
        core_lat   = lat;
        req_valid  = 1'b1;
        req_signed = sg;
        req_src1   = a;
        req_src2   = b;
        dcyc = -1;
        scnt = 0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (stall_o) scnt++;
            if (done_o) begin
                dcyc = c;
                break;
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t        vt[6];
    int          dc, sc, cv0, dn0, tcyc;
    bit          byp, ok;
    logic [31:0] exp_hi, exp_lo, d, ra, rb;
    logic        rsg;
    logic [63:0] rr;
    int          rlat;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        vt[0] = '{1'b0, 32'd100,        32'd7,          10, 32'd14,         32'd2};
        vt[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          4,  32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vt[2] = '{1'b0, 32'hFFFF_FFFF,  32'd16,         1,  32'h0FFF_FFFF,  32'h0000_000F};
        vt[3] = '{1'b1, 32'd100,        32'hFFFF_FFFD,  2,  32'hFFFF_FFDF,  32'd1};
        vt[4] = '{1'b0, 32'd9,          32'd4,          6,  32'd2,          32'd1};
        vt[5] = '{1'b0, 32'd7,          32'd0,          3,  32'hFFFF_FFFF,  32'd7};

        rst = 1'b1; req_valid = 1'b0; req_signed = 1'b0; req_src1 = '0; req_src2 = '0;
        flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; mt_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_core", {core_valid, core_signed, core_dividend, core_divisor}, 0);
        check("rst_stall", stall_o, 0);
        tick();

        // Table-driven divides
        foreach (vt[i]) begin
            byp = BYP && (vt[i].b == 32'd0);
            cv0 = cv_cnt;
            do_div(vt[i].sg, vt[i].a, vt[i].b, vt[i].lat, dc, sc);
            check($sformatf("v%0d_lo", i), lo_o, vt[i].lo);
            check($sformatf("v%0d_hi", i), hi_o, vt[i].hi);
            check($sformatf("v%0d_done_cyc", i), dc, byp ? 1 : 2 + vt[i].lat);
            check($sformatf("v%0d_stall_cyc", i), sc, byp ? 1 : 2 + vt[i].lat);
            check($sformatf("v%0d_stall_done", i), stall_o, 0);
            check($sformatf("v%0d_cv_pulses", i), cv_cnt - cv0, byp ? 0 : 1);
            if (!byp) begin
                check($sformatf("v%0d_core_signed", i), core_signed, vt[i].sg);
                check($sformatf("v%0d_core_ops", i), {core_dividend, core_divisor}, {vt[i].a, vt[i].b});
            end
            tick();
            #1;
            check($sformatf("v%0d_done_pulse", i), done_o, 0);
            check($sformatf("v%0d_idle", i), busy_o, 0);
            tick();
        end

        // Flush mid-WAIT: result is drained and discarded
        mthi_we = 1'b1; mt_wdata = 32'h1234; tick();
        mthi_we = 1'b0; mtlo_we = 1'b1; mt_wdata = 32'h5678; tick();
        mtlo_we = 1'b0;
        exp_hi = 32'h1234; exp_lo = 32'h5678;
        #1;
        check("mt_hi", hi_o, exp_hi);
        check("mt_lo", lo_o, exp_lo);
        dn0 = done_cnt;
        core_lat = 10; req_valid = 1'b1; req_signed = 1'b0; req_src1 = 32'd50; req_src2 = 32'd5;
        repeat (5) tick();
        flush = 1'b1; req_valid = 1'b0;
        tick();
        flush = 1'b0;
        #1;
        check("drain_busy", busy_o, 1);
        check("drain_stall_norq", stall_o, 0);
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (core_dout_valid) begin ok = 1'b1; break; end
            tick();
        end
        check("drain_core_ret", ok, 1);
        tick();
        #1;
        check("drain_idle", busy_o, 0);
        check("drain_hi", hi_o, exp_hi);
        check("drain_lo", lo_o, exp_lo);
        check("drain_no_done", done_cnt - dn0, 0);
        tick();

        // New request arriving during DRAIN waits, then completes normally
        core_lat = 10; req_valid = 1'b1; req_signed = 1'b0; req_src1 = 32'd50; req_src2 = 32'd5;
        repeat (5) tick();
        flush = 1'b1; req_valid = 1'b0;
        tick();
        flush = 1'b0;
        tick();
        do_div(1'b0, 32'd81, 32'd9, 3, dc, sc);
        check("drq_done_cyc", dc, 10);
        check("drq_stall_cyc", sc, 10);
        check("drq_lo", lo_o, 9);
        check("drq_hi", hi_o, 0);
        tick();

        // MTHI in the commit cycle loses to the divide; MTLO one cycle later wins
        core_lat = 5; req_valid = 1'b1; req_signed = 1'b0; req_src1 = 32'd9; req_src2 = 32'd4;
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (core_dout_valid) begin ok = 1'b1; break; end
            tick();
        end
        check("race_core_ret", ok, 1);
        mthi_we = 1'b1; mt_wdata = 32'hAAAA;
        tick();
        mthi_we = 1'b0; req_valid = 1'b0; mtlo_we = 1'b1; mt_wdata = 32'h55;
        #1;
        check("race_done", done_o, 1);
        check("race_hi", hi_o, 1);
        check("race_lo", lo_o, 2);
        tick();
        mtlo_we = 1'b0;
        #1;
        check("race_mtlo", lo_o, 32'h55);
        check("race_hi_keep", hi_o, 1);
        exp_hi = 32'd1; exp_lo = 32'h55;
        tick();

        // Flush during ISSUE suppresses the operand pulse
        cv0 = cv_cnt;
        req_valid = 1'b1; req_signed = 1'b0; req_src1 = 32'd20; req_src2 = 32'd3;
        tick();
        flush = 1'b1; req_valid = 1'b0;
        #1;
        check("iflush_cv", core_valid, 0);
        tick();
        flush = 1'b0;
        #1;
        check("iflush_idle", busy_o, 0);
        check("iflush_no_pulse", cv_cnt - cv0, 0);
        tick();

        // Watchdog: core never answers
        core_mute = 1'b1;
        dn0 = done_cnt;
        req_valid = 1'b1; req_signed = 1'b0; req_src1 = 32'd1; req_src2 = 32'd1;
        tcyc = -1;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (timeout_err) begin tcyc = c; break; end
            tick();
        end
        req_valid = 1'b0;
        #1;
        check("tmo_cycle", tcyc, TMO + 2);
        check("tmo_idle", busy_o, 0);
        check("tmo_stall", stall_o, 0);
        check("tmo_hi", hi_o, exp_hi);
        check("tmo_lo", lo_o, exp_lo);
        check("tmo_no_done", done_cnt - dn0, 0);
        core_mute = 1'b0;
        tick();

        // Randomized divides with interleaved MT writes
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                mt_wdata = d;
                if ($urandom_range(0, 1) == 1) begin mthi_we = 1'b1; exp_hi = d; end
                else begin mtlo_we = 1'b1; exp_lo = d; end
                tick();
                mthi_we = 1'b0; mtlo_we = 1'b0;
                #1;
                check($sformatf("r%0d_mt", i), {hi_o, lo_o}, {exp_hi, exp_lo});
            end
            rsg  = 1'($urandom_range(0, 1));
            ra   = $urandom;
            rb   = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
            rlat = $urandom_range(1, 12);
            rr   = ref_div(rsg, ra, rb);
            exp_lo = rr[63:32];
            exp_hi = rr[31:0];
            byp = BYP && (rb == 32'd0);
            do_div(rsg, ra, rb, rlat, dc, sc);
            check($sformatf("r%0d_lo", i), lo_o, exp_lo);
            check($sformatf("r%0d_hi", i), hi_o, exp_hi);
            check($sformatf("r%0d_done_cyc", i), dc, byp ? 1 : 2 + rlat);
            check($sformatf("r%0d_stall_cyc", i), sc, byp ? 1 : 2 + rlat);
            tick();
        end

        #1;
        check("tmo_sticky", timeout_err, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
